// File: rtl/song_pkg.sv
// Shared definitions for the note-table sequencer: FSM states and
// the field layout of a 16-bit note word.
package song_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        PLAY,
        END,
        HOLD
    } state_e;

    localparam int unsigned DUR_MSB   = 15;
    localparam int unsigned DUR_LSB   = 10;
    localparam int unsigned PITCH_MSB = 9;
    localparam int unsigned PITCH_LSB = 0;

    localparam logic [5:0] DUR_END = 6'd0;

    function automatic logic [5:0] note_duration(input logic [15:0] word);
        return word[DUR_MSB:DUR_LSB];
    endfunction

    function automatic logic [9:0] note_pitch(input logic [15:0] word);
        return word[PITCH_MSB:PITCH_LSB];
    endfunction

endpackage

// File: rtl/tone_divider.sv
// Square-wave generator: toggles Tone every half_period clocks while enabled,
// holding Tone low whenever disabled or when the latched period is zero.
module tone_divider (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] half_period,
    input  logic        enable,
    output logic        Tone
);

    logic [15:0] period_q;
    logic [15:0] half_cnt_q;
    logic        tone_q;

    // NOTE: reset is synchronous, so it is the first branch of the clocked
    // block; all state updates use <= so every branch sees pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            period_q   <= '0;
            half_cnt_q <= '0;
            tone_q     <= 1'b0;
        end else if (load) begin
            period_q   <= half_period;
            half_cnt_q <= half_period - 16'd1;
            tone_q     <= 1'b0;
        end else if (!enable) begin
            tone_q <= 1'b0;
        end else if (period_q != 16'd0) begin
            if (half_cnt_q == 16'd0) begin
                half_cnt_q <= period_q - 16'd1;
                tone_q     <= ~tone_q;
            end else begin
                half_cnt_q <= half_cnt_q - 16'd1;
            end
        end
    end

    assign Tone = tone_q;

endmodule

// File: rtl/song_note_sequencer.sv
// Walks a note table in data memory through port B and plays each note
// as a square wave for its duration; one FSM owns the pointer and timing.
module song_note_sequencer
    import song_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'h0100,
    parameter int unsigned MAX_NOTES   = 64,
    parameter int unsigned BEAT_CYCLES = 8,
    parameter int unsigned PITCH_SCALE = 1,
    parameter bit          LOOP        = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        Song_Select,
    input  logic [15:0] data_b,
    output logic [15:0] Address_B,
    output logic        Tone,
    output logic        Playing,
    output logic        Song_Done
);

    localparam logic [15:0] LAST_ADDR = 16'(BASE_ADDR + MAX_NOTES - 1);
    localparam logic [15:0] BEAT16    = 16'(BEAT_CYCLES);
    localparam logic [15:0] PSCALE16  = 16'(PITCH_SCALE);

    state_e      state_q;
    logic [15:0] ptr_q;
    logic [15:0] dur_cnt_q;
    logic        playing_q;
    logic        done_q;

    logic [5:0]  data_dur;
    logic [9:0]  data_pitch;
    logic [15:0] dur_cycles;
    logic [15:0] half_period;
    logic        abort;
    logic        tone_load;
    logic        tone_en;

    assign data_dur    = note_duration(data_b);
    assign data_pitch  = note_pitch(data_b);
    assign dur_cycles  = 16'(data_dur) * BEAT16;
    assign half_period = 16'(data_pitch) * PSCALE16;

    assign abort     = !Song_Select && (state_q inside {FETCH, LATCH, PLAY});
    assign tone_load = (state_q == LATCH) && Song_Select && (data_dur != DUR_END);
    // Dropping enable on the last PLAY clock forces Tone low at note end.
    assign tone_en   = (state_q == PLAY) && Song_Select && (dur_cnt_q != 16'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= BASE_ADDR;
            dur_cnt_q <= '0;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
        end else if (abort) begin
            state_q   <= IDLE;
            ptr_q     <= BASE_ADDR;
            dur_cnt_q <= '0;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    ptr_q <= BASE_ADDR;
                    if (Song_Select) begin
                        state_q   <= FETCH;
                        playing_q <= 1'b1;
                    end
                end
                FETCH: state_q <= LATCH;
                LATCH: begin
                    if (data_dur == DUR_END) begin
                        state_q   <= END;
                        playing_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        state_q   <= PLAY;
                        dur_cnt_q <= dur_cycles - 16'd1;
                    end
                end
                PLAY: begin
                    if (dur_cnt_q != 16'd0) begin
                        dur_cnt_q <= dur_cnt_q - 16'd1;
                    end else if (ptr_q == LAST_ADDR) begin
                        state_q   <= END;
                        playing_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        ptr_q   <= ptr_q + 16'd1;
                        state_q <= FETCH;
                    end
                end
                END: begin
                    ptr_q <= BASE_ADDR;
                    if (LOOP && Song_Select) begin
                        state_q   <= FETCH;
                        playing_q <= 1'b1;
                    end else begin
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (!Song_Select) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    tone_divider u_tone (
        .clock       (clock),
        .reset       (reset),
        .load        (tone_load),
        .half_period (half_period),
        .enable      (tone_en),
        .Tone        (Tone)
    );

    assign Address_B = ptr_q;
    assign Playing   = playing_q;
    assign Song_Done = done_q;

endmodule

// File: tb/tb_song_note_sequencer.sv
// Self-checking bench: three sequencer instances (default, LOOP=1, MAX_NOTES=4)
// compared cycle by cycle against a trace predicted from the note table.
module tb_song_note_sequencer;

    localparam logic [15:0] BASE    = 16'h0100;
    localparam logic [18:0] IDLE_EV = {16'h0100, 3'b000};

    logic        clock = 1'b0;
    logic        reset;
    logic        sel_a, sel_l, sel_m;
    logic [15:0] data_a, data_l, data_m;
    logic [15:0] addr_a, addr_l, addr_m;
    logic        tone_a, tone_l, tone_m;
    logic        play_a, play_l, play_m;
    logic        done_a, done_l, done_m;
    logic [18:0] obs_a, obs_l, obs_m;

    logic [15:0] mem [0:255];
    logic [18:0] exp_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clock = ~clock;

    song_note_sequencer #(.BASE_ADDR(16'h0100), .MAX_NOTES(64), .BEAT_CYCLES(8),
                          .PITCH_SCALE(1), .LOOP(1'b0)) dut_a (
        .clock(clock), .reset(reset), .Song_Select(sel_a), .data_b(data_a),
        .Address_B(addr_a), .Tone(tone_a), .Playing(play_a), .Song_Done(done_a));

    song_note_sequencer #(.BASE_ADDR(16'h0100), .MAX_NOTES(64), .BEAT_CYCLES(8),
                          .PITCH_SCALE(1), .LOOP(1'b1)) dut_l (
        .clock(clock), .reset(reset), .Song_Select(sel_l), .data_b(data_l),
        .Address_B(addr_l), .Tone(tone_l), .Playing(play_l), .Song_Done(done_l));

    song_note_sequencer #(.BASE_ADDR(16'h0100), .MAX_NOTES(4), .BEAT_CYCLES(8),
                          .PITCH_SCALE(1), .LOOP(1'b0)) dut_m (
        .clock(clock), .reset(reset), .Song_Select(sel_m), .data_b(data_m),
        .Address_B(addr_m), .Tone(tone_m), .Playing(play_m), .Song_Done(done_m));

    assign obs_a = {addr_a, tone_a, play_a, done_a};
    assign obs_l = {addr_l, tone_l, play_l, done_l};
    assign obs_m = {addr_m, tone_m, play_m, done_m};

    function automatic logic [15:0] rd(input logic [15:0] a);
        return (a[15:8] == 8'h01) ? mem[a[7:0]] : 16'hFFFF;
    endfunction

    // Synchronous-read memory: data valid one clock after the address.
    always @(posedge clock) begin
        data_a <= rd(addr_a);
        data_l <= rd(addr_l);
        data_m <= rd(addr_m);
    end

    // Expected per-cycle {Address_B, Tone, Playing, Song_Done} after a select rise.
    task automatic model_song(input int max_notes, input int passes);
        for (int k = 0; k < passes; k++) begin
            for (int i = 0; i < 256; i++) begin
                logic [15:0] w;
                logic [15:0] addr;
                int d;
                int p;
                w    = mem[i];
                d    = int'(w[15:10]);
                p    = int'(w[9:0]);
                addr = BASE + 16'(i);
                exp_q.push_back({addr, 3'b010});
                exp_q.push_back({addr, 3'b010});
                if (d == 0) begin
                    exp_q.push_back({addr, 3'b001});
                    break;
                end
                for (int t = 0; t < d * 8; t++)
                    exp_q.push_back({addr, (p != 0) && ((t / p) % 2 == 1), 2'b10});
                if (i == max_notes - 1) begin
                    exp_q.push_back({addr, 3'b001});
                    break;
                end
            end
        end
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(IDLE_EV);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        sel_a = 1'b0; sel_l = 1'b0; sel_m = 1'b0;
        repeat (2) @(negedge clock);
        n_tests++;
        if (obs_a !== IDLE_EV) begin
            n_fail++; $display("FAIL reset_a got %h want %h", obs_a, IDLE_EV);
        end
        n_tests++;
        if (obs_l !== IDLE_EV) begin
            n_fail++; $display("FAIL reset_l got %h want %h", obs_l, IDLE_EV);
        end
        n_tests++;
        if (obs_m !== IDLE_EV) begin
            n_fail++; $display("FAIL reset_m got %h want %h", obs_m, IDLE_EV);
        end
        reset = 1'b0;
        repeat (2) @(negedge clock);
        n_tests++;
        if (obs_a !== IDLE_EV) begin
            n_fail++; $display("FAIL idle_after_reset got %h want %h", obs_a, IDLE_EV);
        end
    endtask

    task automatic test_single_note;
        logic [18:0] exp;
        int cyc = 0;
        mem[0] = 16'h0403;
        mem[1] = 16'h0000;
        exp_q.delete();
        model_song(64, 1);
        push_idle(4);
        sel_a = 1'b1;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            @(negedge clock);
            n_tests++;
            if (obs_a !== exp) begin
                n_fail++;
                $display("FAIL single_note cyc %0d addr/tone/play/done got %h/%b/%b/%b want %h/%b/%b/%b",
                         cyc, obs_a[18:3], obs_a[2], obs_a[1], obs_a[0], exp[18:3], exp[2], exp[1], exp[0]);
            end
            cyc++;
        end
        sel_a = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_rest;
        logic [18:0] exp;
        int cyc = 0;
        mem[0] = 16'h0800;
        mem[1] = 16'h0000;
        exp_q.delete();
        model_song(64, 1);
        push_idle(2);
        sel_a = 1'b1;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            @(negedge clock);
            n_tests++;
            if (obs_a !== exp) begin
                n_fail++;
                $display("FAIL rest cyc %0d got %h want %h (addr,tone,play,done)", cyc, obs_a, exp);
            end
            cyc++;
        end
        sel_a = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_abort;
        logic [18:0] exp;
        mem[0] = 16'h0C05;
        mem[1] = 16'h0000;
        exp_q.delete();
        model_song(64, 1);
        sel_a = 1'b1;
        for (int cyc = 0; cyc < 7; cyc++) begin
            exp = exp_q.pop_front();
            @(negedge clock);
            n_tests++;
            if (obs_a !== exp) begin
                n_fail++;
                $display("FAIL abort_pre cyc %0d got %h want %h", cyc, obs_a, exp);
            end
        end
        sel_a = 1'b0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clock);
            n_tests++;
            if (obs_a !== IDLE_EV) begin
                n_fail++;
                $display("FAIL abort_post cyc %0d got %h want %h", cyc, obs_a, IDLE_EV);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_no_retrigger;
        logic [18:0] exp;
        int cyc = 0;
        mem[0] = 16'h0402;
        mem[1] = 16'h0000;
        exp_q.delete();
        model_song(64, 1);
        push_idle(10);
        sel_a = 1'b1;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            @(negedge clock);
            n_tests++;
            if (obs_a !== exp) begin
                n_fail++;
                $display("FAIL hold cyc %0d got %h want %h", cyc, obs_a, exp);
            end
            cyc++;
        end
        sel_a = 1'b0;
        @(negedge clock);
        model_song(64, 1);
        push_idle(2);
        sel_a = 1'b1;
        cyc = 0;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            @(negedge clock);
            n_tests++;
            if (obs_a !== exp) begin
                n_fail++;
                $display("FAIL replay cyc %0d got %h want %h", cyc, obs_a, exp);
            end
            cyc++;
        end
        sel_a = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_loop;
        logic [18:0] exp;
        int cyc = 0;
        mem[0] = 16'h0402;
        mem[1] = 16'h0000;
        exp_q.delete();
        model_song(64, 2);
        sel_l = 1'b1;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            @(negedge clock);
            n_tests++;
            if (obs_l !== exp) begin
                n_fail++;
                $display("FAIL loop cyc %0d got %h want %h", cyc, obs_l, exp);
            end
            cyc++;
        end
        sel_l = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            n_tests++;
            if (obs_l !== IDLE_EV) begin
                n_fail++;
                $display("FAIL loop_stop cyc %0d got %h want %h", i, obs_l, IDLE_EV);
            end
        end
    endtask

    task automatic test_max_notes;
        logic [18:0] exp;
        logic [5:0]  d;
        logic [9:0]  p;
        int cyc = 0;
        for (int i = 0; i < 6; i++) begin
            d = 6'($urandom_range(1, 2));
            p = 10'($urandom_range(0, 6));
            mem[i] = {d, p};
        end
        exp_q.delete();
        model_song(4, 1);
        push_idle(3);
        sel_m = 1'b1;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            @(negedge clock);
            n_tests++;
            if (obs_m !== exp) begin
                n_fail++;
                $display("FAIL max_notes cyc %0d got %h want %h", cyc, obs_m, exp);
            end
            cyc++;
        end
        sel_m = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset_mid_note;
        logic [18:0] exp;
        int cyc = 0;
        mem[0] = 16'h0C05;
        mem[1] = 16'h0000;
        exp_q.delete();
        model_song(64, 1);
        sel_a = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp = exp_q.pop_front();
            @(negedge clock);
            n_tests++;
            if (obs_a !== exp) begin
                n_fail++;
                $display("FAIL rst_pre cyc %0d got %h want %h", i, obs_a, exp);
            end
        end
        exp_q.delete();
        reset = 1'b1;
        @(negedge clock);
        n_tests++;
        if (obs_a !== IDLE_EV) begin
            n_fail++;
            $display("FAIL rst_mid got %h want %h", obs_a, IDLE_EV);
        end
        reset = 1'b0;
        model_song(64, 1);
        push_idle(2);
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            @(negedge clock);
            n_tests++;
            if (obs_a !== exp) begin
                n_fail++;
                $display("FAIL rst_restart cyc %0d got %h want %h", cyc, obs_a, exp);
            end
            cyc++;
        end
        sel_a = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_random_songs;
        logic [18:0] exp;
        logic [5:0]  d;
        logic [9:0]  p;
        int n;
        int cyc;
        for (int it = 0; it < 8; it++) begin
            n = int'($urandom_range(1, 5));
            for (int i = 0; i < n; i++) begin
                d = 6'($urandom_range(1, 3));
                p = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 7));
                mem[i] = {d, p};
            end
            mem[n] = 16'h0000;
            exp_q.delete();
            model_song(64, 1);
            push_idle(3);
            sel_a = 1'b1;
            cyc = 0;
            while (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                @(negedge clock);
                n_tests++;
                if (obs_a !== exp) begin
                    n_fail++;
                    $display("FAIL random it %0d cyc %0d got %h want %h", it, cyc, obs_a, exp);
                end
                cyc++;
            end
            sel_a = 1'b0;
            repeat (2) @(negedge clock);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hFFFF;
        test_reset;
        test_single_note;
        test_rest;
        test_abort;
        test_no_retrigger;
        test_loop;
        test_max_notes;
        test_reset_mid_note;
        test_random_songs;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
